// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch slice.
package fetch_pkg;

    localparam int          FETCH_W  = 32;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam int          PC_STEP  = 4;

    typedef struct packed {
        logic [FETCH_W-1:0] pc;
        logic [FETCH_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_if.sv
// Bus bundle between the fetch unit, instruction memory, execute (redirects) and decode.
interface ifetch_if #(
    parameter int IMEM_W = 14,
    parameter int W      = 32
);
    logic [IMEM_W-1:0] imem_addr_o;
    logic [W-1:0]      imem_data_i;
    logic              redirect_i;
    logic [W-1:0]      redirect_pc_i;
    logic              inst_valid_o;
    logic              inst_ready_i;
    logic [W-1:0]      inst_o;
    logic [W-1:0]      inst_pc_o;
    logic              misalign_o;

    modport master (
        output imem_addr_o,
        input  imem_data_i,
        input  redirect_i,
        input  redirect_pc_i,
        output inst_valid_o,
        input  inst_ready_i,
        output inst_o,
        output inst_pc_o,
        output misalign_o
    );

    modport slave (
        input  imem_addr_o,
        output imem_data_i,
        output redirect_i,
        output redirect_pc_i,
        input  inst_valid_o,
        output inst_ready_i,
        input  inst_o,
        input  inst_pc_o,
        input  misalign_o
    );
endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, inst} entries; flush beats push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  fetch_entry_t     wdata_i,
    output fetch_entry_t     rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == {CNT_W{1'b0}});
    assign count_o = count_q;
    assign rdata_o = mem_q[head_q];

    // Qualify requests against occupancy; a full FIFO may still accept when it pops.
    always_comb begin
        do_pop_s  = pop_i & ~empty_o;
        do_push_s = push_i & (~full_o | do_pop_s);
    end

    // Next-state pointers and occupancy.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = {PTR_W{1'b0}};
            tail_d  = {PTR_W{1'b0}};
            count_d = {CNT_W{1'b0}};
        end else begin
            head_d  = head_q + PTR_W'(do_pop_s);
            tail_d  = tail_q + PTR_W'(do_push_s);
            count_d = count_q + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= {PTR_W{1'b0}};
            tail_q  <= {PTR_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are only observed through a valid head.
    always_ff @(posedge clk_i) begin
        if (do_push_s && !flush_i && !rst_i) begin
            mem_q[tail_q] <= wdata_i;
        end else begin
            mem_q[tail_q] <= mem_q[tail_q];
        end
    end

endmodule

// File: rtl/ifetch.sv
// Instruction-fetch initiator: fetch PC, misalignment halt, prefetch buffering to decode.
module ifetch
    import fetch_pkg::*;
#(
    parameter int            IMEM_W   = 14,
    parameter int            W        = FETCH_W,
    parameter int            DEPTH    = 2,
    parameter logic [W-1:0]  RESET_PC = {W{1'b0}}
) (
    input  logic     clk_i,
    input  logic     rst_i,
    ifetch_if.master bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [W-1:0]     fetch_pc_q, fetch_pc_d;
    logic             misalign_q, misalign_d;
    logic             push_s;
    logic             pop_s;
    logic             inst_valid_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [CNT_W-1:0] fifo_count_s;
    fetch_entry_t     entry_wr_s;
    fetch_entry_t     entry_rd_s;

    // Handshake and fetch arbitration; redirect and a halted fetch suppress pushes.
    always_comb begin
        inst_valid_s = ~fifo_empty_s;
        pop_s        = bus.inst_ready_i & (fifo_count_s != {CNT_W{1'b0}});
        push_s       = ~bus.redirect_i & ~misalign_q & (~fifo_full_s | pop_s);
        entry_wr_s   = '{pc: fetch_pc_q, inst: bus.imem_data_i};
    end

    // Next fetch PC and sticky misalignment flag.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        misalign_d = misalign_q;
        if (bus.redirect_i) begin
            fetch_pc_d = bus.redirect_pc_i;
            misalign_d = (bus.redirect_pc_i[1:0] != 2'b00);
        end else if (push_s) begin
            fetch_pc_d = fetch_pc_q + W'(PC_STEP);
            misalign_d = misalign_q;
        end else begin
            fetch_pc_d = fetch_pc_q;
            misalign_d = misalign_q;
        end
    end

    // Fetch PC and misalignment registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_q <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            misalign_q <= misalign_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .flush_i (bus.redirect_i),
        .wdata_i (entry_wr_s),
        .rdata_o (entry_rd_s),
        .count_o (fifo_count_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Head is zeroed whenever it does not hold a valid instruction.
    always_comb begin
        bus.imem_addr_o  = fetch_pc_q[IMEM_W-1:0];
        bus.inst_valid_o = inst_valid_s;
        bus.misalign_o   = misalign_q;
        if (inst_valid_s) begin
            bus.inst_o    = entry_rd_s.inst;
            bus.inst_pc_o = entry_rd_s.pc;
        end else begin
            bus.inst_o    = {W{1'b0}};
            bus.inst_pc_o = {W{1'b0}};
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: queue-based reference model plus directed literal checks.
module tb_ifetch;

    localparam int IMEM_W = 14;
    localparam int W      = 32;
    localparam int DEPTH  = 2;
    localparam int NWORDS = 1 << (IMEM_W - 2);

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ifetch_if #(.IMEM_W(IMEM_W), .W(W)) bus ();

    ifetch #(
        .IMEM_W   (IMEM_W),
        .W        (W),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [NWORDS];
    assign bus.imem_data_i = mem[bus.imem_addr_o[IMEM_W-1:2]];

    int   n_cmp = 0;
    int   n_bad = 0;
    bit   chk_en = 1'b0;
    ent_t q[$];
    logic [31:0] m_pc  = 32'h0;
    logic        m_mis = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model step, applied with the inputs present at a rising edge.
    task automatic model_step();
        bit   pop;
        ent_t e;
        pop = (q.size() != 0) && bus.inst_ready_i;
        if (rst) begin
            q.delete();
            m_pc  = 32'h0;
            m_mis = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (bus.redirect_i) begin
                q.delete();
                m_pc  = bus.redirect_pc_i;
                m_mis = (bus.redirect_pc_i[1:0] != 2'b00);
            end else if (!m_mis && q.size() < DEPTH) begin
                e.pc   = m_pc;
                e.inst = mem[m_pc[IMEM_W-1:2]];
                q.push_back(e);
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    // One clock: drive inputs after the falling edge, advance the model at the rising edge.
    task automatic cyc(input logic r, input logic red, input logic [31:0] rpc, input logic rdy);
        @(negedge clk);
        #1;
        rst               = r;
        bus.redirect_i    = red;
        bus.redirect_pc_i = rpc;
        bus.inst_ready_i  = rdy;
        @(posedge clk);
        model_step();
        #2;
    endtask

    // Cycle-by-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("valid",    {31'd0, bus.inst_valid_o}, {31'd0, q.size() != 0});
            check("inst",     bus.inst_o,    (q.size() != 0) ? q[0].inst : 32'h0);
            check("inst_pc",  bus.inst_pc_o, (q.size() != 0) ? q[0].pc   : 32'h0);
            check("misalign", {31'd0, bus.misalign_o}, {31'd0, m_mis});
            check("imem_addr", {18'd0, bus.imem_addr_o}, {18'd0, m_pc[IMEM_W-1:0]});
        end
    end

    initial begin
        logic [31:0] rpc;
        int          sel;
        for (int i = 0; i < NWORDS; i++) mem[i] = 32'h1000_0000 + 32'(i);
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'h0;
        bus.inst_ready_i  = 1'b0;

        // Reset state
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        chk_en = 1'b1;
        check("rst_valid", {31'd0, bus.inst_valid_o}, 32'd0);
        check("rst_mis",   {31'd0, bus.misalign_o},   32'd0);
        check("rst_addr",  {18'd0, bus.imem_addr_o},  32'd0);
        check("rst_inst",  bus.inst_o,                32'd0);

        // Streaming, one per cycle
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        check("s0_pc",   bus.inst_pc_o, 32'h0);
        check("s0_inst", bus.inst_o,    32'h1000_0000);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        check("s1_pc",   bus.inst_pc_o, 32'h4);
        check("s1_inst", bus.inst_o,    32'h1000_0001);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        check("s2_pc",   bus.inst_pc_o, 32'h8);
        check("s2_inst", bus.inst_o,    32'h1000_0002);

        // Back-pressure: DEPTH entries buffered, fetch address frozen
        cyc(1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 32'h0, 1'b0);
        check("stall_addr", {18'd0, bus.imem_addr_o}, 32'd8);
        check("stall_pc",   bus.inst_pc_o, 32'h0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        check("drain_pc1", bus.inst_pc_o, 32'h4);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        check("drain_pc2", bus.inst_pc_o, 32'h8);

        // Redirect while full
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b1, 32'h40, 1'b0);
        check("redir_n1_valid", {31'd0, bus.inst_valid_o}, 32'd0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        check("redir_n2_pc",   bus.inst_pc_o, 32'h40);
        check("redir_n2_inst", bus.inst_o,    32'h1000_0010);

        // Misaligned redirect halts, aligned redirect resumes
        cyc(1'b0, 1'b1, 32'h42, 1'b1);
        check("mis_set",   {31'd0, bus.misalign_o},   32'd1);
        check("mis_valid", {31'd0, bus.inst_valid_o}, 32'd0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        check("mis_hold_valid", {31'd0, bus.inst_valid_o}, 32'd0);
        cyc(1'b0, 1'b1, 32'h80, 1'b1);
        check("mis_clr", {31'd0, bus.misalign_o}, 32'd0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        check("resume_pc", bus.inst_pc_o, 32'h80);

        // imem address wrap keeps the full PC
        cyc(1'b0, 1'b1, 32'h3FFC, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        check("wrap_addr",    {18'd0, bus.imem_addr_o}, 32'd0);
        check("wrap_pc_last", bus.inst_pc_o, 32'h3FFC);
        check("wrap_inst",    bus.inst_o,    32'h1000_0FFF);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        check("wrap_pc",      bus.inst_pc_o, 32'h4000);
        check("wrap_inst0",   bus.inst_o,    32'h1000_0000);

        // Reset mid-operation with buffered entries and an active pop
        cyc(1'b0, 1'b1, 32'h42, 1'b0);
        cyc(1'b0, 1'b1, 32'h100, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 1'b1);
        check("mrst_valid", {31'd0, bus.inst_valid_o}, 32'd0);
        check("mrst_mis",   {31'd0, bus.misalign_o},   32'd0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1);
        check("mrst_pc", bus.inst_pc_o, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 6)        rpc = {16'd0, 2'b00, 12'($urandom_range(0, NWORDS - 1)), 2'b00};
            else if (sel < 8)   rpc = $urandom() & 32'hFFFF_FFFC;
            else if (sel < 9)   rpc = 32'hFFFF_FFF8;
            else if (sel < 11)  rpc = {16'd0, 14'($urandom_range(0, 16383))} | 32'h1;
            else                rpc = 32'h0;
            cyc(($urandom_range(0, 199) == 0),
                (sel < 11),
                rpc,
                ($urandom_range(0, 9) < 7));
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
